// File: rtl/hilo_acc_pkg.sv
// Shared encodings for the HI/LO multiply-accumulate register block.
package hilo_acc_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_MADD = 2'b01,
    OP_MSUB = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_addsub.sv
// Wide modular adder/subtractor used for the {HI,LO} accumulate; carry/borrow out is dropped.
module hilo_addsub #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/hilo_acc.sv
// HI/LO register pair with an optional two-cycle multiply-accumulate (MADD/MSUB) path.
// The accumulate state machine and datapath are built only when HILO_ACC_EN is defined.
module hilo_acc
  import hilo_acc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_hi,
  input  logic            we_lo,
  input  logic [DW-1:0]   hi_i,
  input  logic [DW-1:0]   lo_i,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [2*DW-1:0] prod_i,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o
);

  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

`ifdef HILO_ACC_EN
  state_e          state_q, state_d;
  logic [2*DW-1:0] prod_q, prod_d;
  logic            sub_q, sub_d;
  logic            done_q, done_d;
  logic [2*DW-1:0] acc_sum;

  hilo_addsub #(.W(2*DW)) u_addsub (
    .a   ({hi_q, lo_q}),
    .b   (prod_q),
    .sub (sub_q),
    .y   (acc_sum)
  );

  // Writes land on the start edge, so the CALC cycle naturally sees the fresh HI/LO.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    sub_d   = sub_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (we_hi) hi_d = hi_i;
        if (we_lo) lo_d = lo_i;
        if (start && op_is_valid(op)) begin
          state_d = ST_CALC;
          prod_d  = prod_i;
          sub_d   = (op == OP_MSUB);
        end
      end
      ST_CALC: begin
        state_d = ST_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = acc_sum;
          done_d       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prod_q  <= '0;
      sub_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      sub_q   <= sub_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_CALC);
  assign done = done_q;
`else
  // Accumulate controls are intentionally dropped in the plain register build.
  logic unused_acc_inputs;
  assign unused_acc_inputs = ^{start, op, prod_i, flush};

  always_comb begin
    hi_d = we_hi ? hi_i : hi_q;
    lo_d = we_lo ? lo_i : lo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign busy = 1'b0;
  assign done = 1'b0;
`endif

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: doc/hilo_acc.md
HILO_ACC -- requirements
Module: hilo_acc

Interface
REQ-001 The block SHALL take parameter DW (default 32), the width of each of HI and LO.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port we_hi, input, 1 bit: write enable for HI.
REQ-006 Port we_lo, input, 1 bit: write enable for LO.
REQ-007 Port hi_i, input, DW bits: HI write data.
REQ-008 Port lo_i, input, DW bits: LO write data.
REQ-009 Port start, input, 1 bit: request an accumulate operation.
REQ-010 Port op, input, 2 bits: operation code; 01 = MADD, 10 = MSUB, 00 and 11 are reserved.
REQ-011 Port prod_i, input, 2*DW bits: product operand, sampled with start.
REQ-012 Port flush, input, 1 bit: cancel an in-flight accumulate.
REQ-013 Port busy, output, 1 bit: accumulate in progress.
REQ-014 Port done, output, 1 bit: one-cycle pulse on accumulate completion.
REQ-015 Port hi_o, output, DW bits: current HI value.
REQ-016 Port lo_o, output, DW bits: current LO value.

Function
REQ-017 hi_o and lo_o SHALL be registered, with no combinational path from any input.
REQ-018 In IDLE, a clock edge with we_hi=1 SHALL load hi_i into HI, and an edge with we_lo=1 SHALL load lo_i into LO; each half is independent.
REQ-019 The state machine SHALL have two states, IDLE and CALC; busy SHALL be 1 exactly while in CALC.
REQ-020 In IDLE, start=1 with op of 01 or 10 SHALL latch prod_i and op and move to CALC on the same edge.
REQ-021 In IDLE, start=1 with op of 00 or 11 SHALL be ignored: no state change, no done pulse.
REQ-022 If start and we_hi/we_lo are asserted together in IDLE, the write SHALL be applied on that edge and the accumulate SHALL use the newly written values.
REQ-023 In CALC with flush=0, the next edge SHALL store {HI,LO} +/- prod into {HI,LO} (+ for MADD, - for MSUB), return to IDLE, and set done=1 for exactly one cycle.
REQ-024 The accumulate result is 2*DW-bit arithmetic modulo 2^(2*DW); carry-out and borrow SHALL be discarded.
REQ-025 In CALC, we_hi, we_lo and start SHALL be ignored.
REQ-026 In CALC, flush=1 SHALL return the block to IDLE with HI/LO unchanged and no done pulse.
REQ-027 In IDLE, flush SHALL have no effect.
REQ-028 Accumulate latency SHALL be 2 edges from start to updated hi_o/lo_o; done SHALL be high in the same cycle the new values appear.
REQ-029 Back-to-back operation: a start is accepted in the cycle done is high, since the block is in IDLE.

Reset
REQ-030 rst=1 SHALL asynchronously clear HI, LO, busy, done and the latched operand, and force IDLE.
REQ-031 Reset during CALC SHALL abort the operation with no write and no done pulse.
REQ-032 After reset deasserts, the first edge SHALL behave as IDLE.

Configuration
REQ-033 With macro HILO_ACC_EN defined, the accumulate datapath and state machine SHALL be compiled in as above.
REQ-034 Without HILO_ACC_EN, start, op, prod_i and flush SHALL be ignored, busy and done SHALL be tied to 0, and the block SHALL reduce to a HI/LO register with independent per-half write enables.

Structure
REQ-035 The op encodings (NOP=00, MADD=01, MSUB=10, RSV=11) and the state encodings (IDLE, CALC) SHALL live in the shared package or defines file.
REQ-036 The 2*DW-bit add/subtract SHALL be the sub-module hilo_addsub (inputs a, b, sub; output y).

Verification (DW=32)
REQ-037 Reset, then we_hi=1, hi_i=0x12345678 with we_lo=0 -> after 1 edge hi_o=0x12345678 and lo_o=0.
REQ-038 HI=0, LO=0xFFFFFFFF; start, op=MADD, prod_i=1 -> busy=1 for 1 cycle, then hi_o=1, lo_o=0, done=1 for 1 cycle.
REQ-039 HI=0, LO=0; start, op=MSUB, prod_i=1 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFF (wrap).
REQ-040 MADD started, then flush=1 in CALC -> HI/LO unchanged, done stays 0, busy=0 next cycle.
REQ-041 we_lo=1 with lo_i=5 while in CALC -> write dropped; result reflects accumulate only.
REQ-042 rst asserted mid-CALC -> outputs zero immediately with no done; plus start with op=11 -> busy stays 0.
